mult_div_sequencer: RTL and testbench
=====================================

# mult_div_sequencer

Multi-cycle controller that computes unsigned 32x32 multiply (MULTU) and unsigned 32/32 divide (DIVU) by sequencing the shared 32-bit combinational ALU. Sits beside the ALU in the execute stage. The block drives the ALU operand and control lines, samples `alu_result` each cycle, and produces 64-bit HI/LO results through a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request pulse. Sampled only while `busy`=0.
- `op`  in  1  0 = MULTU, 1 = DIVU. Sampled with `start`.
- `src_a`  in  32  multiplicand or dividend.
- `src_b`  in  32  multiplier or divisor.
- `busy`  out  1  high from the edge after an accepted start until the result is written.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi`  out  32  product[63:32] or remainder. Held until the next completion.
- `lo`  out  32  product[31:0] or quotient. Held until the next completion.
- `alu_a`  out  32  ALU operand 1.
- `alu_b`  out  32  ALU operand 2.
- `alu_ctrl`  out  4  ALU control code.
- `alu_shamt`  out  5  ALU shift amount. Always 0.
- `alu_result`  in  32  combinational ALU result for the current cycle.

## Operation
Internal registers:
- `M` (32): multiplicand or divisor.
- `H` (32): running HI or remainder.
- `L` (32): running LO or quotient.
- `T` (32): temporary.
- `cnt` (6).

States: IDLE, MUL_STEP, MUL_CARRY, DIV_CMP, DIV_SUB, DONE.

Accept:
- In IDLE or DONE with `start`=1, load `cnt`=0, `M`=`src_b` (DIVU) or `src_a` (MULTU).
- MULTU: `H`=0, `L`=`src_b`. Go to MUL_STEP.
- DIVU: `H`=0, `L`=`src_a`. Go to DIV_CMP.

MUL_STEP:
- If `L[0]`=0: `{H,L}` >>= 1 with 0 shifted in, `cnt`++. No ALU use.
- If `L[0]`=1: drive ADD(`H`,`M`), latch `T`=result, go to MUL_CARRY.

MUL_CARRY:
- Drive SLT(`T`,`H`). The carry is `alu_result[0]` (unsigned compare).
- `{H,L}` = `{carry,T,L}` >> 1, `cnt`++, return to MUL_STEP.

DIV_CMP:
- Form R' = `{H[30:0],L[31]}` and ovf = `H[31]`.
- Drive SLT(R',`M`).
- If ovf=1 or `alu_result[0]`=0: `H`=R', `L`=`L`<<1, go to DIV_SUB.
- Otherwise: `H`=R', `L`=`L`<<1, `cnt`++, stay in DIV_CMP.

DIV_SUB:
- Drive SUB(`H`,`M`), `H`=result, `L[0]`=1, `cnt`++, go to DIV_CMP.
- Subtraction is modulo 2^32, which is correct when ovf=1.

Termination and outputs:
- The iteration that takes `cnt` to 32 copies `H`→`hi` and `L`→`lo` and enters DONE.
- DONE lasts one cycle with `done`=1, then returns to IDLE unless a new start is accepted.
- Divide by zero has no special case. It yields `lo`=FFFFFFFF and `hi`=dividend.
- When not driving an operation: `alu_a`=`alu_b`=0 and `alu_ctrl`=ADD.
- `start` while `busy`=1 is ignored, with no queueing.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `busy`=0, `done`=0, `hi`=`lo`=0, `alu_a`=`alu_b`=0, `alu_ctrl`=ADD, `alu_shamt`=0, `cnt`=0. This applies mid-operation too; the partial result is discarded.
- The ALU is combinational within one cycle; `alu_result` is sampled at the edge that ends the cycle in which the operands were driven.
- Start is accepted at edge E0. `busy`=1 from E0.
- MULTU: the final iteration completes at edge E(32+k), where k = popcount(`src_b`).
- DIVU: the final iteration completes at edge E(32+k), where k = popcount(quotient).
- `done`=1 and `busy`=0 in the cycle following that edge. Latency ranges from 32 to 64 cycles plus the DONE cycle.
- Start in the DONE cycle is accepted: back-to-back operations have no idle gap. `done` is still 1 that cycle for the previous result.
- `hi`/`lo` change only on completion edges and on reset.

## Structure
- Shared package `mips_alu_pkg`:
  - ALU codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100, SLL=1111.
  - Op encoding MULTU=0, DIVU=1.
  - Sequencer state enum.
- The ALU is instantiated in the parent and shared via a mux owned by the parent. The sequencer contains no ALU copy and no sub-module.

## Test plan
- MULTU 3×5 → `hi`=0, `lo`=15. `done` in the cycle after E34 (k=2). `busy` high for E0..E34.
- MULTU FFFFFFFF×FFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001. Completes at E64, exercising every carry.
- DIVU 100/7 → `lo`=14, `hi`=2. Completes at E35.
- DIVU 00001234/0 → `lo`=FFFFFFFF, `hi`=00001234. Completes at E64.
- Start while busy (MULTU 2×2 mid-DIVU) is ignored and the DIVU result is unaffected. `rst_n`=0 mid-operation → `busy`=`done`=0 and `hi`=`lo`=0 after that edge.
- Start asserted during the DONE cycle → new operation accepted, `done` deasserts next cycle, second result correct.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS execute-stage ALU and the multiply/divide
// sequencer that borrows it.
//   - ALU control codes
//   - multiply/divide op encoding
//   - sequencer state enum
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_DIVU  = 1'b1
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_STEP,
        ST_MUL_CARRY,
        ST_DIV_CMP,
        ST_DIV_SUB,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULTU / DIVU controller that time-shares the execute-stage ALU.
// Shift-and-add multiply and restoring divide, one bit per iteration; an
// iteration that needs an add/subtract takes a second cycle on the ALU.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start, op              request pulse and op (0 MULTU, 1 DIVU), taken when not busy
//   src_a, src_b           multiplicand/dividend, multiplier/divisor
//   busy, done             in progress / one-cycle completion pulse
//   hi, lo                 product[63:32]/remainder, product[31:0]/quotient
//   alu_a, alu_b           ALU operands
//   alu_ctrl, alu_shamt    ALU control code, shift amount (always 0)
//   alu_result             combinational ALU result for the current cycle
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start, ALU released
// MUL_STEP   | test L[0]: plain shift, or ADD(H,M) into T
// MUL_CARRY  | carry = SLT(T,H), shift {carry,T,L} right one
// DIV_CMP    | shift {H,L} left, compare remainder against divisor
// DIV_SUB    | H -= M, set quotient bit
// DONE       | result valid, done pulse; may accept the next start
module mult_div_sequencer
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    seq_state_t       state, state_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [WIDTH-1:0] h_reg, h_next;
    logic [WIDTH-1:0] l_reg, l_next;
    logic [WIDTH-1:0] t_reg, t_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [5:0]       cnt_reg, cnt_next;
    logic             last_iter;
    logic [WIDTH-1:0] div_shift;

    assign last_iter = (cnt_reg == CNT_LAST);
    // Remainder after pulling in the next dividend bit; its lost MSB is H[31].
    assign div_shift = {h_reg[WIDTH-2:0], l_reg[WIDTH-1]};
    assign alu_shamt = 5'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            m_reg   <= '0;
            h_reg   <= '0;
            l_reg   <= '0;
            t_reg   <= '0;
            cnt_reg <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_next;
            m_reg   <= m_next;
            h_reg   <= h_next;
            l_reg   <= l_next;
            t_reg   <= t_next;
            cnt_reg <= cnt_next;
            hi      <= hi_next;
            lo      <= lo_next;
        end
    end

    always_comb begin
        state_next = state;
        m_next     = m_reg;
        h_next     = h_reg;
        l_next     = l_reg;
        t_next     = t_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi;
        lo_next    = lo;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = ALU_ADD;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                done       = (state == ST_DONE);
                state_next = ST_IDLE;
                if (start) begin
                    cnt_next = '0;
                    h_next   = '0;
                    if (op == OP_DIVU) begin
                        m_next     = src_b;
                        l_next     = src_a;
                        state_next = ST_DIV_CMP;
                    end else begin
                        m_next     = src_a;
                        l_next     = src_b;
                        state_next = ST_MUL_STEP;
                    end
                end
            end

            ST_MUL_STEP: begin
                busy = 1'b1;
                if (!l_reg[0]) begin
                    h_next   = {1'b0, h_reg[WIDTH-1:1]};
                    l_next   = {h_reg[0], l_reg[WIDTH-1:1]};
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    alu_a      = h_reg;
                    alu_b      = m_reg;
                    alu_ctrl   = ALU_ADD;
                    t_next     = alu_result;
                    state_next = ST_MUL_CARRY;
                end
                if (!l_reg[0] && last_iter) begin
                    hi_next    = h_next;
                    lo_next    = l_next;
                    state_next = ST_DONE;
                end
            end

            ST_MUL_CARRY: begin
                busy     = 1'b1;
                // The sum wrapped exactly when it is below an addend (unsigned).
                alu_a    = t_reg;
                alu_b    = h_reg;
                alu_ctrl = ALU_SLT;
                h_next   = {alu_result[0], t_reg[WIDTH-1:1]};
                l_next   = {t_reg[0], l_reg[WIDTH-1:1]};
                cnt_next = cnt_reg + 6'd1;
                if (last_iter) begin
                    hi_next    = h_next;
                    lo_next    = l_next;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_MUL_STEP;
                end
            end

            ST_DIV_CMP: begin
                busy     = 1'b1;
                alu_a    = div_shift;
                alu_b    = m_reg;
                alu_ctrl = ALU_SLT;
                h_next   = div_shift;
                l_next   = {l_reg[WIDTH-2:0], 1'b0};
                if (h_reg[WIDTH-1] || !alu_result[0]) begin
                    state_next = ST_DIV_SUB;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                    if (last_iter) begin
                        hi_next    = h_next;
                        lo_next    = l_next;
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DIV_SUB: begin
                busy     = 1'b1;
                // Modulo-2^32 subtract is still right when the 33-bit remainder overflowed.
                alu_a    = h_reg;
                alu_b    = m_reg;
                alu_ctrl = ALU_SUB;
                h_next   = alu_result;
                l_next   = {l_reg[WIDTH-1:1], 1'b1};
                cnt_next = cnt_reg + 6'd1;
                if (last_iter) begin
                    hi_next    = h_next;
                    lo_next    = l_next;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DIV_CMP;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;

    int total;
    int bad;

    logic [63:0] exp_q[$];

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result)
    );

    // Environment ALU (the parent's shared ALU); SLT is an unsigned compare.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'd0, (alu_a < alu_b)};
            4'b1100: alu_result = ~(alu_a | alu_b);
            4'b1111: alu_result = alu_b << alu_shamt;
            default: alu_result = 32'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic o, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        logic [63:0] p;
        logic [31:0] q;
        v.op = o;
        v.a  = a;
        v.b  = b;
        if (o == 1'b0) begin
            p     = 64'(a) * 64'(b);
            v.hi  = p[63:32];
            v.lo  = p[31:0];
            v.lat = 32 + $countones(b);
        end else begin
            if (b == 32'd0) begin
                q    = 32'hFFFF_FFFF;
                v.hi = a;
            end else begin
                q    = a / b;
                v.hi = a % b;
            end
            v.lo  = q;
            v.lat = 32 + $countones(q);
        end
        return v;
    endfunction

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hilo", {hi, lo}, e);
            end
        end
    end

    // Drive a start from just after an edge; returns 1 ns after the accept edge E0.
    task automatic begin_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_hilo);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        exp_q.push_back(exp_hilo);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Returns 1 ns after the completion edge (inside the DONE cycle).
    task automatic wait_done(input string name, input int exp_lat);
        int n;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({name, "_latency"}, 64'(n), 64'(exp_lat));
            check({name, "_busy_low"}, {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        src_a = '0;
        src_b = '0;

        // Test-plan vectors first, then a few model-derived ones.
        vecs.push_back('{1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 34});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 64});
        vecs.push_back('{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 35});
        vecs.push_back('{1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 64});
        vecs.push_back(mk(1'b0, 32'd0, 32'd0));
        vecs.push_back(mk(1'b0, 32'h1234_5678, 32'h9ABC_DEF0));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFFF, 32'd1));
        vecs.push_back(mk(1'b1, 32'd7, 32'd100));
        vecs.push_back(mk(1'b1, 32'h8000_0000, 32'd3));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFFF, 32'h8000_0001));
        vecs.push_back(mk(1'b0, $urandom, $urandom));
        vecs.push_back(mk(1'b1, $urandom, $urandom_range(1, 65535)));

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'(4'b0010));
        check("rst_alu_shamt", 64'(alu_shamt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            begin_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
            wait_done($sformatf("vec%0d", i), vecs[i].lat);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d_idle_alu", i), {alu_a, alu_b}, 64'd0);
        end

        // Start while busy is ignored; no extra done may follow.
        begin_op(1'b1, 32'd100, 32'd7, {32'd2, 32'd14});
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b0;
        src_a = 32'd2;
        src_b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignored_start", 35 - 11);
        repeat (70) @(posedge clk);
        #1;
        check("ignored_no_second_op", {hi, lo}, {32'd2, 32'd14});

        // Reset mid-operation discards the partial result.
        begin_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: start during the DONE cycle.
        begin_op(1'b0, 32'd3, 32'd5, {32'd0, 32'd15});
        wait_done("b2b_first", 34);
        begin_op(1'b1, 32'd100, 32'd7, {32'd2, 32'd14});
        check("b2b_done_drops", {63'd0, done}, 64'd0);
        wait_done("b2b_second", 35);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
